dbus_arbiter: RTL and testbench

- Shares the single data-bus port (dbus_req_t / dbus_resp_t) between N requesters, e.g. the memory stage and the page-table walker.
- Grants one requester at a time and latches its request so the downstream request stays stable.
- Holds ownership until the downstream data_ok, then routes the response back to the owner only.
- Sits between the pipeline / MMU request sources and the cache or bus interface.

---
 rtl/arb_pkg.sv | 42 ++++
 rtl/rr_picker.sv | 43 ++++
 rtl/dbus_arbiter.sv | 101 ++++++++++
 tb/tb_dbus_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the data-bus arbiter: the bus request/response structs,
// the arbiter state encoding and the pointer-width helper.
package arb_pkg;

  localparam int ARB_MAX_N = 8;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Owner/pointer index width; a lone requester still gets one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection: rotating priority starting at rr_ptr,
// or fixed lowest-index priority when ROUND_ROBIN is 0.
module rr_picker
  import arb_pkg::*;
#(
  parameter int N           = 2,
  parameter bit ROUND_ROBIN = 1'b1,
  localparam int PW         = ptr_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] rr_ptr,
  output logic          any,
  output logic [PW-1:0] winner
);

  logic [PW-1:0] w_base;

  assign w_base = ROUND_ROBIN ? rr_ptr : '0;

  // Each valid index gets its distance from the base with an explicit wrap,
  // so non-power-of-two N works; the smallest distance wins.
  always_comb begin
    int best_d;
    int d;
    // NOTE: every output gets a default before the loop so no path can infer a latch.
    any    = 1'b0;
    winner = '0;
    best_d = N;
    d      = 0;
    for (int i = 0; i < N; i++) begin
      if (valid[i]) begin
        d = i - int'(w_base);
        if (d < 0) d = d + N;
        if (d < best_d) begin
          best_d = d;
          winner = PW'(i);
          any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Shares one data-bus port between N requesters: one owner at a time, its request
// latched until the downstream data_ok, and the response routed to the owner only.
module dbus_arbiter
  import arb_pkg::*;
#(
  parameter int N           = 2,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  dbus_req_t    req   [N],
  output dbus_resp_t   resp  [N],
  output dbus_req_t    dreq,
  input  dbus_resp_t   dresp,
  output logic [N-1:0] grant,
  output logic         busy
);

  localparam int PW = ptr_width(N);

  arb_state_t    r_state;
  logic [PW-1:0] r_owner;
  logic [PW-1:0] r_rr_ptr;
  dbus_req_t     r_dreq;
  logic [N-1:0]  r_grant;
  logic          r_busy;

  logic [N-1:0]  w_valid;
  logic          w_any;
  logic [PW-1:0] w_winner;

  always_comb begin
    for (int i = 0; i < N; i++) w_valid[i] = req[i].valid;
  end

  rr_picker #(
    .N           (N),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_picker (
    .valid  (w_valid),
    .rr_ptr (r_rr_ptr),
    .any    (w_any),
    .winner (w_winner)
  );

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ARB_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_dreq   <= '0;
      r_grant  <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_owner <= w_winner;
            r_dreq  <= req[w_winner];
            r_grant <= N'(1) << w_winner;
            r_busy  <= 1'b1;
            r_state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // addr_ok alone keeps ownership; only data_ok ends the transaction.
          if (dresp.data_ok) begin
            r_dreq  <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= ARB_IDLE;
            if (ROUND_ROBIN) begin
              r_rr_ptr <= (r_owner == PW'(N - 1)) ? '0 : r_owner + PW'(1);
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign dreq  = r_dreq;
  assign grant = r_grant;
  assign busy  = r_busy;

  // Gating with reset drops a data_ok that coincides with a reset cycle.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      resp[j] = '0;
      if (r_state == ARB_BUSY && !reset && r_owner == PW'(j)) resp[j] = dresp;
    end
  end

  a_n_range: assert property (@(posedge clk) (N >= 2) && (N <= ARB_MAX_N));
  a_grant_onehot: assert property (@(posedge clk) $onehot0(grant));
  a_busy_state: assert property (@(posedge clk) busy == (r_state == ARB_BUSY));
  a_dreq_stable: assert property (@(posedge clk)
    (r_state == ARB_BUSY && !dresp.data_ok && !reset) |=> $stable(dreq));

endmodule

// File: tb/tb_dbus_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter side by side and compares every
// output each cycle against a transaction-level reference model.
module tb_dbus_arbiter;
  import arb_pkg::*;

  localparam int N           = 2;
  localparam int RAND_CYCLES = 3000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Index 0 drives the round-robin instance, index 1 the fixed-priority one.
  dbus_req_t    req_s   [2][N];
  dbus_resp_t   dresp_s [2];
  dbus_resp_t   resp_s  [2][N];
  dbus_req_t    dreq_s  [2];
  logic [N-1:0] grant_s [2];
  logic         busy_s  [2];

  dbus_req_t    req_a [N], req_b [N];
  dbus_resp_t   resp_a [N], resp_b [N];
  dbus_req_t    dreq_a, dreq_b;
  dbus_resp_t   dresp_a, dresp_b;
  logic [N-1:0] grant_a, grant_b;
  logic         busy_a, busy_b;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      req_a[k]     = req_s[0][k];
      req_b[k]     = req_s[1][k];
      resp_s[0][k] = resp_a[k];
      resp_s[1][k] = resp_b[k];
    end
    dresp_a    = dresp_s[0];
    dresp_b    = dresp_s[1];
    dreq_s[0]  = dreq_a;
    dreq_s[1]  = dreq_b;
    grant_s[0] = grant_a;
    grant_s[1] = grant_b;
    busy_s[0]  = busy_a;
    busy_s[1]  = busy_b;
  end

  dbus_arbiter #(.N(N), .ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .reset(reset), .req(req_a), .resp(resp_a),
    .dreq(dreq_a), .dresp(dresp_a), .grant(grant_a), .busy(busy_a)
  );

  dbus_arbiter #(.N(N), .ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .reset(reset), .req(req_b), .resp(resp_b),
    .dreq(dreq_b), .dresp(dresp_b), .grant(grant_b), .busy(busy_b)
  );

  // Reference model: who owns the bus, what it asked for, where priority starts.
  bit        m_busy  [2];
  int        m_owner [2];
  int        m_ptr   [2];
  dbus_req_t m_lat   [2];
  bit        got_ok  [2][N];
  int        gcnt    [2][N];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int x = 0; x < 2; x++) begin
      m_busy[x]  = 1'b0;
      m_owner[x] = 0;
      m_ptr[x]   = 0;
      m_lat[x]   = '0;
      for (int i = 0; i < N; i++) got_ok[x][i] = 1'b0;
    end
  endtask

  // Next model state from the inputs present at the clock edge.
  task automatic advance(input int x);
    for (int i = 0; i < N; i++) got_ok[x][i] = 1'b0;
    if (reset) begin
      m_busy[x]  = 1'b0;
      m_owner[x] = 0;
      m_ptr[x]   = 0;
      m_lat[x]   = '0;
    end else if (m_busy[x]) begin
      if (dresp_s[x].data_ok) begin
        got_ok[x][m_owner[x]] = 1'b1;
        m_busy[x] = 1'b0;
        if (x == 0) m_ptr[x] = (m_owner[x] + 1) % N;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = ((x == 0 ? m_ptr[x] : 0) + k) % N;
        if (!m_busy[x] && req_s[x][idx].valid) begin
          m_busy[x]  = 1'b1;
          m_owner[x] = idx;
          m_lat[x]   = req_s[x][idx];
        end
      end
    end
  endtask

  task automatic compare_all();
    dbus_req_t    e_dreq;
    logic [N-1:0] e_grant;
    dbus_resp_t   e_resp;
    #1;
    for (int x = 0; x < 2; x++) begin
      e_dreq  = m_busy[x] ? m_lat[x] : '0;
      e_grant = '0;
      if (m_busy[x]) e_grant[m_owner[x]] = 1'b1;
      check($sformatf("inst%0d dreq", x), dreq_s[x], e_dreq);
      check($sformatf("inst%0d grant", x), grant_s[x], e_grant);
      check($sformatf("inst%0d busy", x), busy_s[x], m_busy[x]);
      for (int j = 0; j < N; j++) begin
        e_resp = (m_busy[x] && m_owner[x] == j && !reset) ? dresp_s[x] : '0;
        check($sformatf("inst%0d resp[%0d]", x, j), resp_s[x][j], e_resp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int x = 0; x < 2; x++) advance(x);
    @(negedge clk);
  endtask

  function automatic dbus_req_t mk_req(input logic [63:0] addr, input msize_t size,
                                       input logic [7:0] strobe, input logic [63:0] data);
    dbus_req_t r;
    r.valid  = 1'b1;
    r.addr   = addr;
    r.size   = size;
    r.strobe = strobe;
    r.data   = data;
    return r;
  endfunction

  function automatic dbus_req_t rand_req();
    return mk_req({32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFF8)},
                  msize_t'($urandom_range(0, 3)), 8'($urandom), {$urandom, $urandom});
  endfunction

  task automatic set_req(input int i, input dbus_req_t r);
    for (int x = 0; x < 2; x++) req_s[x][i] = r;
  endtask

  task automatic set_dresp(input bit a, input bit d, input logic [63:0] data);
    for (int x = 0; x < 2; x++) dresp_s[x] = '{addr_ok: a, data_ok: d, data: data};
  endtask

  // Requesters hold valid until their data_ok; the owner may alter or abandon its request.
  task automatic rand_inputs();
    reset = ($urandom_range(0, 63) == 0);
    for (int x = 0; x < 2; x++) begin
      for (int i = 0; i < N; i++) begin
        if (got_ok[x][i]) begin
          req_s[x][i] = ($urandom_range(0, 3) == 0) ? rand_req() : '0;
        end else if (!req_s[x][i].valid) begin
          if ($urandom_range(0, 2) == 0) req_s[x][i] = rand_req();
        end else if (m_busy[x] && m_owner[x] == i) begin
          case ($urandom_range(0, 15))
            0:       req_s[x][i].valid = 1'b0;
            1, 2, 3: req_s[x][i].addr  = req_s[x][i].addr + 64'd8;
            default: ;
          endcase
        end
      end
      dresp_s[x].addr_ok = 1'($urandom);
      dresp_s[x].data_ok = m_busy[x] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
      dresp_s[x].data    = {$urandom, $urandom};
    end
  endtask

  initial begin
    for (int x = 0; x < 2; x++) begin
      for (int i = 0; i < N; i++) begin
        req_s[x][i] = '0;
        gcnt[x][i]  = 0;
      end
    end
    set_dresp(1'b0, 1'b0, 64'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Single requester load: dreq.valid one cycle later, response at cycle 3.
    set_req(0, mk_req(64'h8000_1000, MSIZE8, 8'h00, 64'h0));
    compare_all();
    tick();
    compare_all();
    check("t1 dreq.valid at cycle 1", dreq_s[0].valid, 1'b1);
    tick();
    compare_all();
    tick();
    set_dresp(1'b0, 1'b1, 64'h1122_3344_5566_7788);
    compare_all();
    check("t1 resp0.data_ok", resp_s[0][0].data_ok, 1'b1);
    check("t1 resp0.data", resp_s[0][0].data, 64'h1122_3344_5566_7788);
    check("t1 resp1 quiet", resp_s[0][1], 130'h0);
    tick();
    set_req(0, '0);
    set_dresp(1'b0, 1'b0, 64'h0);
    compare_all();
    check("t1 busy low at cycle 4", busy_s[0], 1'b0);
    tick();

    // Both requesters always valid, data_ok on the first busy cycle.
    set_req(0, mk_req(64'h8000_2000, MSIZE4, 8'h0F, 64'h0));
    set_req(1, mk_req(64'h8000_3000, MSIZE4, 8'hF0, 64'h1));
    for (int t = 0; t < 16; t++) begin
      for (int x = 0; x < 2; x++)
        dresp_s[x] = '{addr_ok: m_busy[x], data_ok: m_busy[x], data: 64'(t)};
      compare_all();
      for (int x = 0; x < 2; x++)
        for (int i = 0; i < N; i++)
          if (grant_s[x][i]) gcnt[x][i]++;
      tick();
    end
    check("t2 rr grants to req0", gcnt[0][0], 4);
    check("t2 rr grants to req1", gcnt[0][1], 4);
    check("t3 fp grants to req0", gcnt[1][0], 8);
    check("t3 fp grants to req1", gcnt[1][1], 0);
    set_req(0, '0);
    set_dresp(1'b0, 1'b0, 64'h0);
    compare_all();
    tick();
    set_dresp(1'b1, 1'b1, 64'h55);
    compare_all();
    check("t3 fp grants req1 after req0 drops", grant_s[1], 2'b10);
    tick();
    set_req(1, '0);
    set_dresp(1'b0, 1'b0, 64'h0);
    compare_all();
    tick();

    // Owner changes its address while the downstream stalls.
    set_req(0, mk_req(64'h8000_0000, MSIZE8, 8'h00, 64'h0));
    compare_all();
    tick();
    req_s[0][0].addr = 64'h8000_0008;
    req_s[1][0].addr = 64'h8000_0008;
    for (int t = 0; t < 6; t++) begin
      if (t == 5) set_dresp(1'b1, 1'b1, 64'hA5);
      compare_all();
      check($sformatf("t4 dreq.addr held cycle %0d", t + 1), dreq_s[0].addr, 64'h8000_0000);
      tick();
    end
    set_req(0, '0);
    set_dresp(1'b0, 1'b0, 64'h0);
    compare_all();
    tick();

    // Split handshake: addr_ok at cycle 2, data_ok at cycle 4.
    set_req(0, mk_req(64'h8000_0100, MSIZE4, 8'h00, 64'h0));
    compare_all();
    tick();
    compare_all();
    tick();
    set_dresp(1'b1, 1'b0, 64'h0);
    compare_all();
    check("t5 resp0.addr_ok at cycle 2", resp_s[0][0].addr_ok, 1'b1);
    check("t5 resp0.data_ok quiet at cycle 2", resp_s[0][0].data_ok, 1'b0);
    tick();
    set_dresp(1'b0, 1'b0, 64'h0);
    compare_all();
    check("t5 busy at cycle 3", busy_s[0], 1'b1);
    tick();
    set_dresp(1'b0, 1'b1, 64'h0BAD);
    compare_all();
    check("t5 resp0.data_ok at cycle 4", resp_s[0][0].data_ok, 1'b1);
    tick();
    set_req(0, '0);
    set_dresp(1'b0, 1'b0, 64'h0);
    compare_all();
    check("t5 idle at cycle 5", busy_s[0], 1'b0);
    tick();

    // Reset during a store; a data_ok in the reset cycle must not count.
    set_req(0, mk_req(64'h8000_4000, MSIZE8, 8'hF0, 64'hDEAD_BEEF_0BAD_F00D));
    compare_all();
    tick();
    compare_all();
    check("t6 store strobe", dreq_s[0].strobe, 8'hF0);
    tick();
    reset = 1'b1;
    set_dresp(1'b1, 1'b1, 64'h77);
    compare_all();
    tick();
    reset = 1'b0;
    set_dresp(1'b0, 1'b0, 64'h0);
    set_req(1, mk_req(64'h8000_5000, MSIZE2, 8'h03, 64'h0));
    compare_all();
    check("t6 dreq.valid after reset", dreq_s[0].valid, 1'b0);
    check("t6 grant after reset", grant_s[0], 2'b00);
    tick();
    compare_all();
    check("t6 rr restarts at req0", grant_s[0], 2'b01);
    tick();

    for (int c = 0; c < RAND_CYCLES; c++) begin
      rand_inputs();
      compare_all();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
